// File: rtl/fb_scan_reader.sv
// fb_scan_reader: streams one framebuffer frame out in raster order.
//
// On a start request in IDLE the block walks every (x, y) of a WIDTH x HEIGHT
// frame, issues single-cycle framebuffer reads (data returns one cycle later),
// captures each returned colour with its coordinates into a 2-entry FIFO and
// presents the FIFO head on a valid/ready pixel stream. done pulses once per
// completed frame.
//
// Ports:
//   clk, reset              sole clock (rising edge), synchronous active-high reset
//   start                   single-cycle frame request, honoured only in IDLE
//   busy, done              scan in progress / one-cycle end-of-frame pulse
//   mem_addr, mem_rd        read address (y*WIDTH+x) and strobe
//   mem_rdata               colour for the read issued in the previous cycle
//   pix_x, pix_y,
//   pix_colour, pix_valid   presented pixel
//   pix_ready               sink accept; transfer when pix_valid && pix_ready
//
// Build option: define FB_SCAN_SKIP_BLACK_EN to drop returned pixels of colour
// 3'b000 instead of presenting them.
module fb_scan_reader #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [14:0] mem_addr,
  output logic        mem_rd,
  input  logic [2:0]  mem_rdata,
  output logic [7:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [2:0]  pix_colour,
  output logic        pix_valid,
  input  logic        pix_ready
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [7:0] XLAST = 8'(WIDTH - 1);
  localparam logic [6:0] YLAST = 7'(HEIGHT - 1);

  state_t      state_q, state_d;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [14:0] lin_q;       // y*WIDTH+x, kept as a running count
  logic [14:0] addr_q;      // last issued address, shown while mem_rd is low
  logic        pend_q;      // a read was issued last cycle
  logic [7:0]  pend_x_q;
  logic [6:0]  pend_y_q;

  logic [7:0]  fx_q [2];
  logic [6:0]  fy_q [2];
  logic [2:0]  fc_q [2];
  logic        wptr_q, rptr_q;
  logic [1:0]  cnt_q;

  logic        pop, push, last_xy;
  logic [2:0]  occ_eff;

  assign pix_valid  = (cnt_q != 2'd0);
  assign pix_x      = fx_q[rptr_q];
  assign pix_y      = fy_q[rptr_q];
  assign pix_colour = fc_q[rptr_q];
  assign busy       = (state_q == SCAN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign mem_addr   = mem_rd ? lin_q : addr_q;

  assign pop     = pix_valid && pix_ready;
  assign last_xy = (x_q == XLAST) && (y_q == YLAST);

`ifdef FB_SCAN_SKIP_BLACK_EN
  assign push = pend_q && (mem_rdata != 3'b000);
`else
  assign push = pend_q;
`endif

  // Occupancy counts the entry leaving this cycle as already gone, so a
  // ready sink sees back-to-back reads and one pixel per cycle.
  assign occ_eff = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, pend_q};

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SCAN;
      SCAN: begin
        if (occ_eff < 3'd2) begin
          mem_rd = 1'b1;
          if (last_xy) state_d = DRAIN;
        end
      end
      DRAIN: if ((cnt_q == 2'd0) && !pend_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      lin_q    <= '0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fx_q[i] <= '0;
        fy_q[i] <= '0;
        fc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= mem_rd;

      if ((state_q == IDLE) && start) begin
        x_q   <= '0;
        y_q   <= '0;
        lin_q <= '0;
      end else if (mem_rd) begin
        addr_q   <= lin_q;
        pend_x_q <= x_q;
        pend_y_q <= y_q;
        lin_q    <= lin_q + 15'd1;
        if (x_q == XLAST) begin
          x_q <= '0;
          y_q <= y_q + 7'd1;
        end else begin
          x_q <= x_q + 8'd1;
        end
      end

      if (push) begin
        fx_q[wptr_q] <= pend_x_q;
        fy_q[wptr_q] <= pend_y_q;
        fc_q[wptr_q] <= mem_rdata;
        wptr_q       <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
module tb_fb_scan_reader;

  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        reset, start, pix_ready;
  logic        busy, done, mem_rd, pix_valid;
  logic [14:0] mem_addr;
  logic [2:0]  mem_rdata = '0;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;

  always #5 clk = ~clk;

  fb_scan_reader #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  int checks = 0;
  int errors = 0;
  int mem_mode = 0;   // 0: colour = addr mod 8; 1: all black except addr 321

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] mem_colour(input logic [14:0] a);
    if (mem_mode == 1) return (a == 15'd321) ? 3'b100 : 3'b000;
    return 3'(int'(a) % 8);
  endfunction

  // Framebuffer: answers one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_colour(mem_addr);
    else        mem_rdata <= 3'($urandom);
  end

  // Reference stream state: reads issued, pixels accepted, done pulses seen.
  bit         mon_en = 0;
  int         issued, xfers, done_cnt;
  bit         stall_q;
  logic [7:0] sx;
  logic [6:0] sy;
  logic [2:0] sc;

  task automatic clear_model();
    issued = 0; xfers = 0; done_cnt = 0; stall_q = 0;
  endtask

  task automatic sample();
    bit pop;
    int outst, ex, ey, ec;
    pop = pix_valid && pix_ready;
    if (mem_rd) begin
      chk("rd_addr", 32'(mem_addr), issued);
      if (mem_mode == 0) begin
        // every read not yet accepted is either buffered or still returning
        outst = issued - xfers - (pop ? 1 : 0);
        chk("rd_pacing", (outst < 2) ? 1 : 0, 1);
      end
      issued++;
    end
    if (stall_q) begin
      chk("stall_valid", pix_valid, 1);
      chk("stall_x", pix_x, sx);
      chk("stall_y", pix_y, sy);
      chk("stall_colour", pix_colour, sc);
    end
    if (pop) begin
      if (mem_mode == 0) begin
        ex = xfers % W; ey = xfers / W; ec = xfers % 8;
      end else begin
        ex = 1; ey = 2; ec = 4;
      end
      chk($sformatf("pix_x[%0d]", xfers), pix_x, ex);
      chk($sformatf("pix_y[%0d]", xfers), pix_y, ey);
      chk($sformatf("pix_colour[%0d]", xfers), pix_colour, ec);
      xfers++;
    end
    stall_q = pix_valid && !pix_ready;
    sx = pix_x; sy = pix_y; sc = pix_colour;
    if (done) begin
      done_cnt++;
      chk("done_busy", busy, 0);
    end
  endtask

  // Sample on the falling edge, then re-drive just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (mon_en) sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset = 1; start = 0; pix_ready = 1;
    cyc(); cyc();
    reset = 0;
  endtask

  task automatic run_frame(input bit rnd_ready, input bit noise, input bit with_reset);
    int n;
    if (with_reset) do_reset();
    clear_model();
    mon_en = 1;
    pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1;
    cyc();
    start = 0;
    n = 0;
    while (done_cnt == 0 && n < 60000) begin
      pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = noise && busy && ($urandom_range(0, 39) == 0);
      cyc();
      n++;
    end
    start = 0; pix_ready = 1;
    chk("frame_done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (3) cyc();
    chk("frame_busy_after", busy, 0);
    chk("frame_done_count", done_cnt, 1);
    chk("frame_transfers", xfers, (mem_mode == 1) ? 1 : W * H);
    chk("frame_reads", issued, W * H);
    mon_en = 0;
  endtask

  typedef struct {
    logic        rst, st, rdy;
    logic        busy, done, rd;
    logic [14:0] addr;
    logic        valid;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n;
    reset = 1; start = 0; pix_ready = 1;

`ifdef FB_SCAN_SKIP_BLACK_EN
    mem_mode = 1;
    run_frame(1'b0, 1'b0, 1'b1);
`else
    // Outputs observed in the same cycle the row's inputs are applied.
    tbl[0] = '{1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 1,  1, 0, 1, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 1,  1, 0, 1, 1, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 1,  1, 0, 1, 2, 1, 0, 0, 0};
    tbl[6] = '{0, 1, 1,  1, 0, 1, 3, 1, 1, 0, 1};
    tbl[7] = '{0, 0, 1,  1, 0, 1, 4, 1, 2, 0, 2};

    @(posedge clk); #1;
    cyc(); cyc();
    for (int i = 0; i < 8; i++) begin
      reset = tbl[i].rst; start = tbl[i].st; pix_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
      chk($sformatf("tbl%0d_mem_rd", i), mem_rd, tbl[i].rd);
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_pix_valid", i), pix_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pix_x", i), pix_x, tbl[i].x);
        chk($sformatf("tbl%0d_pix_y", i), pix_y, tbl[i].y);
        chk($sformatf("tbl%0d_pix_colour", i), pix_colour, tbl[i].c);
      end
      @(posedge clk); #1;
    end
    start = 0;

    // Full frame, sink always ready.
    run_frame(1'b0, 1'b0, 1'b1);
    // Full frame, sink ready at random, stray start pulses while busy.
    run_frame(1'b1, 1'b1, 1'b1);

    // Abort mid-frame.
    do_reset();
    clear_model();
    mon_en = 1;
    start = 1;
    cyc();
    start = 0;
    n = 0;
    while (xfers < 5000 && n < 30000) begin
      cyc();
      n++;
    end
    chk("abort_reached_5000", (xfers >= 5000) ? 1 : 0, 1);
    reset = 1;
    cyc();
    reset = 0;
    chk("abort_no_done", done_cnt, 0);
    mon_en = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_pix_x", pix_x, 0);
    chk("abort_pix_y", pix_y, 0);
    chk("abort_pix_colour", pix_colour, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("abort_idle_valid%0d", i), pix_valid, 0);
      chk($sformatf("abort_idle_done%0d", i), done, 0);
      chk($sformatf("abort_idle_busy%0d", i), busy, 0);
    end
    @(posedge clk); #1;
    // Fresh start after the abort, sink ready, stray start pulses.
    run_frame(1'b0, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scan_reader.md
FB_SCAN_READER -- requirements
Module: fb_scan_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 160, meaning pixels per row.
REQ-002 SHALL have parameter HEIGHT, default 120, meaning rows per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to scan one frame.
REQ-006 SHALL have port busy  output  1  high while a frame scan is in progress.
REQ-007 SHALL have port done  output  1  single-cycle pulse at end of frame.
REQ-008 SHALL have port mem_addr  output  15  framebuffer read address, y*WIDTH+x.
REQ-009 SHALL have port mem_rd  output  1  read strobe; data returns exactly 1 cycle later.
REQ-010 SHALL have port mem_rdata  input  3  framebuffer colour for the read issued previous cycle.
REQ-011 SHALL have port pix_x  output  8  column of the presented pixel.
REQ-012 SHALL have port pix_y  output  7  row of the presented pixel.
REQ-013 SHALL have port pix_colour  output  3  colour of the presented pixel.
REQ-014 SHALL have port pix_valid  output  1  presented pixel is valid.
REQ-015 SHALL have port pix_ready  input  1  sink accepts; transfer when pix_valid and pix_ready both high.

Function
REQ-016 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-017 SHALL leave IDLE for SCAN on start high, zeroing scan counters x and y; start outside IDLE SHALL be ignored.
REQ-018 SHALL, in SCAN, assert mem_rd with mem_addr=y*WIDTH+x only when output buffer occupancy plus in-flight reads is below 2.
REQ-019 SHALL advance x after each issued read; x=WIDTH-1 wraps to 0 and increments y.
REQ-020 SHALL move SCAN->DRAIN in the cycle after the read of (WIDTH-1, HEIGHT-1) is issued.
REQ-021 SHALL capture mem_rdata with its issuing coordinates into a 2-entry FIFO one cycle after mem_rd.
REQ-022 SHALL drive pix_valid from FIFO non-empty; pix_x/pix_y/pix_colour SHALL be stable while pix_valid is high and pix_ready is low.
REQ-023 SHALL deliver pixels in raster order (row 0 left-to-right first), never dropping or duplicating any.
REQ-024 SHALL support simultaneous FIFO push and pop in the same cycle, occupancy unchanged.
REQ-025 SHALL move DRAIN->DONE when FIFO empty and no read in flight; DONE SHALL assert done for exactly one cycle then return to IDLE.
REQ-026 SHALL assert busy in SCAN and DRAIN, low in IDLE and DONE.
REQ-027 SHALL, with pix_ready held high, assert mem_rd first in the cycle after start, pix_valid two cycles after that, then sustain one pixel per cycle.
REQ-028 SHALL hold mem_addr at its last value when mem_rd is low.

Reset
REQ-029 SHALL on reset enter IDLE, empty the FIFO, discard any in-flight read, and drive busy, done, mem_rd, pix_valid, mem_addr, pix_x, pix_y, pix_colour to 0.
REQ-030 SHALL on reset mid-frame abort without asserting done; data returning the cycle after reset SHALL be discarded.
REQ-031 SHALL give reset priority over start in the same cycle.

Configuration
REQ-032 SHALL, with macro FB_SCAN_SKIP_BLACK_EN defined, discard returned pixels of colour 3'b000 (not pushed to FIFO; counters still advance; done still issued).
REQ-033 SHALL, without FB_SCAN_SKIP_BLACK_EN, present every pixel including colour 000 (WIDTH*HEIGHT transfers per frame).

Verification
REQ-034 SHALL cover: memory returns colour=(addr mod 8), pix_ready=1, start at cycle 0 -> mem_rd cycle 1 addr 0, pix_valid cycle 3, 19200 transfers in raster order, done once, busy low after.
REQ-035 SHALL cover: pix_ready random 50% -> same 19200-pixel sequence, outputs stable while stalled, mem_rd never issued with 2 entries held or pending.
REQ-036 SHALL cover: row wrap -> transfer 160 is (0,1) addr 160; last transfer (159,119) addr 19199.
REQ-037 SHALL cover: reset asserted at transfer 5000 -> next cycle all outputs 0, state IDLE, no done; new start rescans from (0,0).
REQ-038 SHALL cover: start pulses during SCAN -> ignored, exactly one done per frame.
REQ-039 SHALL cover: FB_SCAN_SKIP_BLACK_EN defined, memory all 000 except addr 321 = 3'b100 -> exactly one transfer (1,2,100), then done.
